// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: ChunkWidth bits per cycle, LSB chunk first, borrow rippled through a register.
// Optional borrow-in port for cascading: define SERIAL_SUBTRACTOR_BORROW_IN_EN.
module serial_subtractor #(
  parameter int Width      = 8,
  parameter int ChunkWidth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] minuend_i,
  input  logic [Width-1:0] subtrahend_i,
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
  input  logic             borrow_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] diff_o,
  output logic             borrow_o
);

  localparam int NumChunks = Width / ChunkWidth;
  localparam int CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  generate
    if (Width < 1 || ChunkWidth < 1 || (Width % ChunkWidth) != 0) begin : g_bad_param
      $error("serial_subtractor: ChunkWidth must be >= 1 and divide Width exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // One chunk of the subtraction; the extra MSB is the outgoing borrow.
  function automatic logic [ChunkWidth:0] chunk_sub(input logic [ChunkWidth-1:0] a,
                                                    input logic [ChunkWidth-1:0] b,
                                                    input logic              bin);
    chunk_sub = {1'b0, a} - {1'b0, b} - {{ChunkWidth{1'b0}}, bin};
  endfunction

  state_e                state_r;
  state_e                next_state_s;
  logic [CntW-1:0]       cnt_r;
  logic                  borrow_r;
  logic [Width-1:0]      a_r;
  logic [Width-1:0]      b_r;
  logic [ChunkWidth-1:0] a_chunk_s;
  logic [ChunkWidth-1:0] b_chunk_s;
  logic [ChunkWidth:0]   sub_s;
  logic                  last_s;
  logic                  init_borrow_s;

`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
  assign init_borrow_s = borrow_i;
`else
  assign init_borrow_s = 1'b0;
`endif

  assign a_chunk_s = a_r[int'(cnt_r)*ChunkWidth +: ChunkWidth];
  assign b_chunk_s = b_r[int'(cnt_r)*ChunkWidth +: ChunkWidth];
  assign sub_s     = chunk_sub(a_chunk_s, b_chunk_s, borrow_r);
  assign last_s    = (cnt_r == CntW'(NumChunks - 1));

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and handshake outputs, both derived from the current state.
  always_comb begin
    next_state_s = state_r;
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          next_state_s = BUSY;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = BUSY;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Operand capture, chunk-serial datapath and registered result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r    <= '0;
      borrow_r <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      diff_o   <= '0;
      borrow_o <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid_i) begin
            a_r      <= minuend_i;
            b_r      <= subtrahend_i;
            cnt_r    <= '0;
            borrow_r <= init_borrow_s;
          end
        end
        BUSY: begin
          diff_o[int'(cnt_r)*ChunkWidth +: ChunkWidth] <= sub_s[ChunkWidth-1:0];
          borrow_r <= sub_s[ChunkWidth];
          if (last_s) begin
            cnt_r    <= '0;
            borrow_o <= sub_s[ChunkWidth];
          end else begin
            cnt_r <= cnt_r + CntW'(1);
          end
        end
        DONE: begin
          // result held until the consumer takes it
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed 8/2 instance plus randomized 16/4 instance against an arithmetic model.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1, bo8;
  logic [7:0]  a8 = 8'h00, b8 = 8'h00, d8;
  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0, bo16;
  logic [15:0] a16 = 16'h0000, b16 = 16'h0000, d16;
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
  logic        bin8 = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int rcv      = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  serial_subtractor #(.Width(8), .ChunkWidth(2)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv8), .in_ready_o(ir8),
    .minuend_i(a8), .subtrahend_i(b8),
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    .borrow_i(bin8),
`endif
    .out_valid_o(ov8), .out_ready_i(or8), .diff_o(d8), .borrow_o(bo8)
  );

  serial_subtractor #(.Width(16), .ChunkWidth(4)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv16), .in_ready_o(ir16),
    .minuend_i(a16), .subtrahend_i(b16),
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    .borrow_i(1'b0),
`endif
    .out_valid_o(ov16), .out_ready_i(or16), .diff_o(d16), .borrow_o(bo16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid8(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ov8 && lat < 50);
  endtask

  task automatic do_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] ed, input logic eb);
    int lat;
    logic [8:0] model;
    model = {1'b0, a} - {1'b0, b} - {8'h00, bin};
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, ir8}, 32'd1);
    a8 = a; b8 = b; iv8 = 1'b1;
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    bin8 = bin;
`endif
    @(posedge clk); #1;
    iv8 = 1'b0;
    wait_valid8(lat);
    check({tag, "_latency"}, lat, 32'd4);
    check({tag, "_diff"}, {24'd0, d8}, {24'd0, ed});
    check({tag, "_borrow"}, {31'd0, bo8}, {31'd0, eb});
    check({tag, "_model"}, {23'd0, bo8, d8}, {23'd0, model});
    @(posedge clk); #1;
    check({tag, "_idle_ready"}, {30'd0, ir8, ov8}, 32'd2);
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, ir8}, 32'd1);
    check("rst_out_valid", {31'd0, ov8}, 32'd0);
    check("rst_diff", {24'd0, d8}, 32'd0);
    check("rst_borrow", {31'd0, bo8}, 32'd0);
    check("rst16_state", {30'd0, ir16, ov16}, 32'd2);
    @(negedge clk) rst = 1'b0;

    do_op8("basic", 8'h5A, 8'h21, 1'b0, 8'h39, 1'b0);
    do_op8("neg", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1);
    do_op8("ripple", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    do_op8("equal", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);

    // Backpressure with ignored input during the stall
    or8 = 1'b0;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    wait_valid8(lat);
    check("bp_latency", lat, 32'd4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      iv8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
      check("bp_hold", {22'd0, ov8, ir8, bo8, d8}, {22'd0, 1'b1, 1'b0, 1'b0, 8'h7F});
    end
    @(negedge clk);
    iv8 = 1'b0;
    check("bp_last", {23'd0, ov8, d8}, {23'd0, 1'b1, 8'h7F});
    or8 = 1'b1;
    @(posedge clk); #1;
    check("bp_done", {22'd0, ov8, ir8, bo8, d8}, {22'd0, 1'b0, 1'b1, 1'b0, 8'h7F});
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_ghost", {31'd0, ov8}, 32'd0);

    // Asynchronous reset in the 2nd BUSY cycle
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h3C; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midrst", {21'd0, ov8, ir8, bo8, d8}, {21'd0, 1'b0, 1'b1, 1'b0, 8'h00});
    @(negedge clk) rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_output", {31'd0, ov8}, 32'd0);
    do_op8("after_rst", 8'h03, 8'h01, 1'b0, 8'h02, 1'b0);

`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    do_op8("bin_a", 8'h05, 8'h03, 1'b1, 8'h01, 1'b0);
    do_op8("bin_b", 8'h03, 8'h03, 1'b1, 8'hFF, 1'b1);
    bin8 = 1'b0;
`endif

    // Randomized stream on the 16-bit instance
    fork
      begin : driver
        for (int n = 0; n < 1000; n++) begin
          int bud;
          int gap;
          gap = $urandom_range(0, 2);
          @(negedge clk);
          a16 = 16'($urandom); b16 = 16'($urandom); iv16 = 1'b1;
          bud = 0;
          while (!ir16 && bud < 100) begin
            @(negedge clk);
            bud++;
          end
          if (!ir16) begin
            check("rnd_accept_timeout", 32'd0, 32'd1);
            iv16 = 1'b0;
            break;
          end
          exp_q.push_back({1'b0, a16} - {1'b0, b16});
          @(posedge clk); #1;
          iv16 = 1'b0;
          a16 = 16'($urandom); b16 = 16'($urandom);
          repeat (gap) @(negedge clk);
        end
      end
      begin : monitor
        int cyc;
        logic stalled;
        logic [16:0] held;
        logic [16:0] e;
        cyc = 0;
        stalled = 1'b0;
        held = 17'd0;
        while (rcv < 1000 && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          if (stalled) begin
            check("rnd_hold", {14'd0, ov16, bo16, d16}, {14'd0, 1'b1, held});
          end
          or16 = ($urandom_range(0, 3) != 0);
          if (ov16 && or16) begin
            if (exp_q.size() == 0) begin
              check("rnd_unexpected", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("rnd_result", {15'd0, bo16, d16}, {15'd0, e});
            end
            rcv++;
          end
          stalled = ov16 && !or16;
          held = {bo16, d16};
        end
      end
    join
    check("rnd_count", rcv, 32'd1000);
    check("rnd_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
